addr_stack_ctrl: RTL and testbench

//  Sequencer for the 11-bit address stack (eleven_fifo) in the MicroEV20 core.

---
 rtl/addr_stack_if.sv | 36 +++
 rtl/addr_stack_ctrl.sv | 150 +++++++++++++++
 tb/tb_addr_stack_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/addr_stack_if.sv
// Decoder/controller/stack signal bundle for the address stack sequencer.
// master = request side (decoder), slave = addr_stack_ctrl.
interface addr_stack_if #(
  parameter int unsigned CW = 4
) ();
  logic          call_req;
  logic          imm_req;
  logic          ret_req;
  logic          flush_req;
  logic          req_ack;
  logic          fifo_enable;
  logic          fifo_select;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_clear;
  logic          pc_load;
  logic          ret_err;
  logic          busy;
  logic [CW-1:0] depth;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          underflow;

  modport master (
    output call_req, imm_req, ret_req, flush_req,
    input  req_ack, fifo_enable, fifo_select, fifo_push, fifo_pop, fifo_clear,
           pc_load, ret_err, busy, depth, full, empty, overflow, underflow
  );

  modport slave (
    input  call_req, imm_req, ret_req, flush_req,
    output req_ack, fifo_enable, fifo_select, fifo_push, fifo_pop, fifo_clear,
           pc_load, ret_err, busy, depth, full, empty, overflow, underflow
  );
endinterface

// File: rtl/addr_stack_ctrl.sv
// Sequencer for the 11-bit address stack: call/imm push, return pop, flush.
// Optional macro ADDR_STACK_WRAP_EN: a push while full is issued and the stack drops its oldest entry.
module addr_stack_ctrl #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 11,
  parameter int unsigned CW    = 4
) (
  input  logic        clk,
  input  logic        clear,
  addr_stack_if.slave bus
);

  if (((2 ** CW) <= DEPTH) || (AW == 0)) begin : g_param_check
    $error("addr_stack_ctrl: CW too small for DEPTH or AW is zero");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PUSH  = 3'd1,
    POP   = 3'd2,
    RETV  = 3'd3,
    FLUSH = 3'd4
  } state_t;

  state_t        state_q, state_nxt;
  logic [CW-1:0] depth_q, depth_nxt;
  logic          ovf_q, ovf_nxt;
  logic          unf_q, unf_nxt;
  logic          err_q, err_nxt;
  logic          full_c, empty_c;

  logic ack_nxt, en_nxt, sel_nxt, push_nxt, pop_nxt, clr_nxt, pcl_nxt, rerr_nxt;
  logic ack_q, en_q, sel_q, push_q, pop_q, clr_q, pcl_q, rerr_q, busy_q;

  assign full_c  = (depth_q == CW'(DEPTH));
  assign empty_c = (depth_q == '0);

  // Strobes are computed for the state being entered, so they are high while in it.
  always_comb begin
    state_nxt = state_q;
    depth_nxt = depth_q;
    ovf_nxt   = ovf_q;
    unf_nxt   = unf_q;
    err_nxt   = err_q;
    ack_nxt   = 1'b0;
    en_nxt    = 1'b0;
    sel_nxt   = 1'b0;
    push_nxt  = 1'b0;
    pop_nxt   = 1'b0;
    clr_nxt   = 1'b0;
    pcl_nxt   = 1'b0;
    rerr_nxt  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.flush_req) begin
          state_nxt = FLUSH;
          ack_nxt   = 1'b1;
          clr_nxt   = 1'b1;
          depth_nxt = '0;
          ovf_nxt   = 1'b0;
          unf_nxt   = 1'b0;
        end else if (bus.ret_req) begin
          state_nxt = POP;
          ack_nxt   = 1'b1;
          if (!empty_c) begin
            pop_nxt   = 1'b1;
            depth_nxt = depth_q - CW'(1);
            err_nxt   = 1'b0;
          end else begin
            unf_nxt = 1'b1;
            err_nxt = 1'b1;
          end
        end else if (bus.call_req || bus.imm_req) begin
          state_nxt = PUSH;
          ack_nxt   = 1'b1;
          en_nxt    = 1'b1;
          sel_nxt   = bus.call_req;
          if (!full_c) begin
            push_nxt  = 1'b1;
            depth_nxt = depth_q + CW'(1);
          end else begin
`ifdef ADDR_STACK_WRAP_EN
            push_nxt = 1'b1;
`else
            ovf_nxt  = 1'b1;
`endif
          end
        end
      end
      POP: begin
        state_nxt = RETV;
        pcl_nxt   = 1'b1;
        rerr_nxt  = err_q;
      end
      PUSH, RETV, FLUSH: state_nxt = IDLE;
      default:           state_nxt = IDLE;
    endcase
  end

  // Reset also clears the stack itself through fifo_clear.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      err_q   <= 1'b0;
      ack_q   <= 1'b0;
      en_q    <= 1'b0;
      sel_q   <= 1'b0;
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      clr_q   <= 1'b1;
      pcl_q   <= 1'b0;
      rerr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      depth_q <= depth_nxt;
      ovf_q   <= ovf_nxt;
      unf_q   <= unf_nxt;
      err_q   <= err_nxt;
      ack_q   <= ack_nxt;
      en_q    <= en_nxt;
      sel_q   <= sel_nxt;
      push_q  <= push_nxt;
      pop_q   <= pop_nxt;
      clr_q   <= clr_nxt;
      pcl_q   <= pcl_nxt;
      rerr_q  <= rerr_nxt;
      busy_q  <= (state_nxt != IDLE);
    end
  end

  assign bus.req_ack     = ack_q;
  assign bus.fifo_enable = en_q;
  assign bus.fifo_select = sel_q;
  assign bus.fifo_push   = push_q;
  assign bus.fifo_pop    = pop_q;
  assign bus.fifo_clear  = clr_q;
  assign bus.pc_load     = pcl_q;
  assign bus.ret_err     = rerr_q;
  assign bus.busy        = busy_q;
  assign bus.depth       = depth_q;
  assign bus.full        = full_c;
  assign bus.empty       = empty_c;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = unf_q;

endmodule

// File: tb/tb_addr_stack_ctrl.sv
// Scoreboard bench for addr_stack_ctrl: directed requests queue expected strobe
// snapshots; a negedge monitor compares every cycle that carries ack/pc_load/clear.
module tb_addr_stack_ctrl;
  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  addr_stack_if #(.CW(CW)) bus ();

  addr_stack_ctrl #(.DEPTH(8), .AW(11), .CW(CW)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  typedef struct packed {
    logic          ack, en, sel, push, pop, clr, pcl, rerr;
    logic [CW-1:0] depth;
    logic          ovf, unf;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  mcyc = 0;
  int  last_ack = -10;

  function automatic ev_t mk(input logic ack, en, sel, push, pop, clr, pcl, rerr,
                             input int d, input logic ovf, unf);
    ev_t e;
    e = {ack, en, sel, push, pop, clr, pcl, rerr, CW'(d), ovf, unf};
    return e;
  endfunction

  task automatic exp_push(input logic sel, input logic push, input int d, input logic ovf, input logic unf);
    exp_q.push_back(mk(1, 1, sel, push, 0, 0, 0, 0, d, ovf, unf));
  endtask

  task automatic exp_ret(input logic pop, input int d, input logic ovf, input logic unf, input logic rerr);
    exp_q.push_back(mk(1, 0, 0, 0, pop, 0, 0, 0, d, ovf, unf));
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, rerr, d, ovf, unf));
  endtask

  task automatic exp_flush();
    exp_q.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
  endtask

  // Strobe monitor.
  always @(negedge clk) begin
    ev_t got;
    ev_t e;
    got = {bus.req_ack, bus.fifo_enable, bus.fifo_select, bus.fifo_push, bus.fifo_pop,
           bus.fifo_clear, bus.pc_load, bus.ret_err, bus.depth, bus.overflow, bus.underflow};
    if (bus.req_ack === 1'b1 || bus.pc_load === 1'b1 || bus.fifo_clear === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event cyc=%0d got=%h", mcyc, got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL event cyc=%0d got=%h exp=%h", mcyc, got, e);
        end
      end
      if (bus.pc_load === 1'b1) begin
        total++;
        if (mcyc != last_ack + 1) begin
          bad++;
          $display("FAIL ret_latency got=%0d exp=1", mcyc - last_ack);
        end
      end
      if (bus.req_ack === 1'b1) last_ack = mcyc;
    end
    mcyc++;
  end

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic wait_ack();
    bit seen;
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (bus.req_ack === 1'b1) seen = 1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL ack_timeout got=0 exp=1");
    end
  endtask

  task automatic set_req(input int k, input logic v);
    case (k)
      0:       bus.call_req  = v;
      1:       bus.imm_req   = v;
      2:       bus.ret_req   = v;
      default: bus.flush_req = v;
    endcase
  endtask

  // Raise a request, wait for its ack, drop it in the following cycle, let the FSM settle.
  task automatic do_req(input int k);
    set_req(k, 1'b1);
    wait_ack();
    @(posedge clk);
    #1 set_req(k, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  int pcl_seen;

  initial begin
    bus.call_req  = 1'b0;
    bus.imm_req   = 1'b0;
    bus.ret_req   = 1'b0;
    bus.flush_req = 1'b0;
    clear = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1 clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_depth", int'(bus.depth), 0);
    chk("reset_empty", int'(bus.empty), 1);
    chk("reset_full", int'(bus.full), 0);
    chk("reset_busy", int'(bus.busy), 0);

    // Call push
    exp_push(1, 1, 1, 0, 0);
    do_req(0);
    chk("call_depth", int'(bus.depth), 1);

    // Return with one entry
    exp_ret(1, 0, 0, 0, 0);
    do_req(2);
    chk("ret_depth", int'(bus.depth), 0);
    chk("ret_empty", int'(bus.empty), 1);

    // Nine immediate pushes into an 8-deep stack
    for (int i = 1; i <= 8; i++) begin
      exp_push(0, 1, i, 0, 0);
      do_req(1);
    end
`ifdef ADDR_STACK_WRAP_EN
    exp_push(0, 1, 8, 0, 0);
`else
    exp_push(0, 0, 8, 1, 0);
`endif
    do_req(1);
    chk("full_depth", int'(bus.depth), 8);
    chk("full_flag", int'(bus.full), 1);
`ifdef ADDR_STACK_WRAP_EN
    chk("overflow", int'(bus.overflow), 0);
`else
    chk("overflow", int'(bus.overflow), 1);
`endif

    // Flush, then return on empty stack, then flush clears underflow
    exp_flush();
    do_req(3);
    chk("flush_depth", int'(bus.depth), 0);
    chk("flush_ovf", int'(bus.overflow), 0);
    exp_ret(0, 0, 0, 1, 1);
    do_req(2);
    chk("underflow_set", int'(bus.underflow), 1);
    exp_flush();
    do_req(3);
    chk("underflow_clr", int'(bus.underflow), 0);

    // Priority: flush > ret > call with all three held at depth 3
    for (int i = 1; i <= 3; i++) begin
      exp_push(1, 1, i, 0, 0);
      do_req(0);
    end
    exp_flush();
    exp_ret(0, 0, 0, 1, 1);
    exp_push(1, 1, 1, 0, 1);
    bus.call_req  = 1'b1;
    bus.ret_req   = 1'b1;
    bus.flush_req = 1'b1;
    wait_ack();
    chk("prio_flush_depth", int'(bus.depth), 0);
    @(posedge clk);
    #1 bus.flush_req = 1'b0;
    wait_ack();
    @(posedge clk);
    #1 bus.ret_req = 1'b0;
    wait_ack();
    @(posedge clk);
    #1 bus.call_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("prio_final_depth", int'(bus.depth), 1);
    chk("prio_underflow", int'(bus.underflow), 1);

    // Clear while the return is heading into RETV: pc_load must not pulse
    exp_q.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    bus.ret_req = 1'b1;
    wait_ack();
    clear = 1'b1;
    bus.ret_req = 1'b0;
    pcl_seen = 0;
    @(posedge clk);
    #1 clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.pc_load === 1'b1) pcl_seen++;
    end
    chk("clear_kills_pc_load", pcl_seen, 0);
    chk("clear_underflow", int'(bus.underflow), 0);
    chk("clear_busy", int'(bus.busy), 0);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
